// File: rtl/dispatch_pkg.sv
// Shared types and constants for the microcode dispatcher.
package dispatch_pkg;

  // Default opcode width: instr[31:21].
  localparam int unsigned OPCODE_W = 11;

  // The all-ones opcode stops the dispatcher.
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = '1;

  // Default watchdog limit, in WAIT_EOS cycles without eos.
  localparam int unsigned TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitEos,
    StHalted,
    StError
  } state_e;

endpackage

// File: rtl/dispatch_buf.sv
// One-entry prefetch register with valid/ready handshake.
// A push and a pop in the same cycle leave the new word stored.
module dispatch_buf #(
  parameter int unsigned Width = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  // Push has priority so a simultaneous pop hands the slot to the new word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer state, synchronous reset to empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = !valid_q || pop_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/microcode_dispatch.sv
// Feeds instruction opcodes to a microcode sequencer one segment at a time,
// with a watchdog on end-of-segment and a sticky halt opcode.
module microcode_dispatch #(
  parameter int unsigned OPCODE_W    = dispatch_pkg::OPCODE_W,
  parameter int unsigned TIMEOUT_CYC = dispatch_pkg::TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic                sos,
  input  logic                eos,
  output logic                busy,
  output logic                halted,
  output logic                err_timeout,
  output logic [CNT_W-1:0]    retired
);

  import dispatch_pkg::*;

  // Same value as HALT_OPCODE, sized to this instance's opcode width.
  localparam logic [OPCODE_W-1:0] HaltOp = '1;

  localparam int unsigned      WdW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT_CYC - 1);

  state_e state_q, state_d;

  logic                buf_ready, buf_valid, buf_pop, buf_push;
  logic [OPCODE_W-1:0] buf_op;
  logic                buf_is_halt, terminal, issue, retire;

  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                sos_q, sos_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [WdW-1:0]      wdog_q, wdog_d;

  // Only the opcode field is kept; the operand bits are not needed here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31-OPCODE_W:0];

  assign terminal    = (state_q == StHalted) || (state_q == StError);
  assign instr_ready = buf_ready && !terminal;
  assign buf_push    = instr_valid && instr_ready;
  assign buf_is_halt = (buf_op == HaltOp);

  dispatch_buf #(
    .Width (OPCODE_W)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .data_i  (instr[31 -: OPCODE_W]),
    .ready_o (buf_ready),
    .valid_o (buf_valid),
    .data_o  (buf_op)
  );

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      sos_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      sos_q     <= sos_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      wdog_q    <= wdog_d;
    end
  end

  // Next state, buffer pop and retire decisions.
  always_comb begin
    state_d = state_q;
    buf_pop = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (buf_valid) begin
          buf_pop = 1'b1;
          state_d = buf_is_halt ? StHalted : StIssue;
        end
      end
      StIssue: state_d = StWaitEos;
      StWaitEos: begin
        // eos beats a watchdog expiry landing in the same cycle.
        if (eos) begin
          retire = 1'b1;
          if (buf_valid) begin
            buf_pop = 1'b1;
            state_d = buf_is_halt ? StHalted : StIssue;
          end else begin
            state_d = StIdle;
          end
        end else if (wdog_q == WdLast) begin
          state_d = StError;
        end
      end
      StHalted, StError: state_d = state_q;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and the watchdog.
  always_comb begin
    issue     = buf_pop && !buf_is_halt;
    opcode_d  = issue ? buf_op : opcode_q;
    sos_d     = issue;
    busy_d    = (state_d == StIssue) || (state_d == StWaitEos);
    halted_d  = (state_d == StHalted);
    err_d     = (state_d == StError);
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    // Held at zero outside WAIT_EOS so every segment starts a fresh count.
    wdog_d    = (state_q == StWaitEos && !eos) ? wdog_q + WdW'(1) : '0;
  end

  assign opcode      = opcode_q;
  assign sos         = sos_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err_timeout = err_q;
  assign retired     = retired_q;

endmodule
